// File: rtl/line_pull_scheduler_pkg.sv
// Shared types and source-geometry defaults for the line pull scheduler.
package line_pull_scheduler_pkg;

    localparam int GBA_W = 240;
    localparam int GBA_H = 160;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        DONE
    } lpsState_t;

endpackage

// File: rtl/line_pull_scheduler_scale_counter.sv
// One axis of the integer upscaler: positions steps against a window and
// yields the source index, with a pulse each time a source element is used up.
module scale_counter
    import line_pull_scheduler_pkg::*;
#(
    parameter int OFFSET = 0,
    parameter int LEN    = 1,
    parameter int SCALE  = 1,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    output logic             inWin,
    output logic             wrap,
    output logic [IDX_W-1:0] idx,
    output logic [CNT_W-1:0] count
);

    localparam int REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(OFFSET);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(OFFSET + LEN * SCALE);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(SCALE - 1);

    logic [REP_W-1:0] rep;
    logic [CNT_W-1:0] posCur;
    logic [REP_W-1:0] repCur;
    logic             winCur;
    logic             firstCur;

    // A clear coinciding with a step makes that step element 0.
    always_comb begin
        posCur   = clr ? '0 : count;
        repCur   = clr ? '0 : rep;
        winCur   = (posCur >= WIN_LO) && (posCur < WIN_HI);
        firstCur = (posCur == WIN_LO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            rep   <= '0;
            idx   <= '0;
            inWin <= 1'b0;
            wrap  <= 1'b0;
        end else if (step) begin
            count <= (&posCur) ? posCur : posCur + 1'b1;
            inWin <= winCur;
            wrap  <= winCur && !firstCur && (repCur == REP_MAX);
            if (!winCur || firstCur) begin
                rep <= '0;
                idx <= '0;
            end else if (repCur == REP_MAX) begin
                rep <= '0;
                idx <= idx + 1'b1;
            end else begin
                rep <= repCur + 1'b1;
            end
        end else if (clr) begin
            count <= '0;
            rep   <= '0;
            idx   <= '0;
            inWin <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: rtl/line_pull_scheduler.sv
// Paces line-buffer pulls against the output raster and maps output pixels
// back to upscaled, centred source pixel indices; reports lock and underruns.
module line_pull_scheduler
    import line_pull_scheduler_pkg::*;
#(
    parameter int SRC_W    = GBA_W,
    parameter int SRC_H    = GBA_H,
    parameter int SCALE    = 4,
    parameter int H_OFFSET = 160,
    parameter int V_OFFSET = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frameStart,
    input  logic       lineStart,
    input  logic       pxlEn,
    input  logic       newFrameIn,
    input  logic       sameLine,
    output logic       nextLine,
    output logic [7:0] curPxl,
    output logic       inWindow,
    output logic       locked,
    output logic [7:0] underrunCnt
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] V_END = CNT_W'(V_OFFSET + SRC_H * SCALE);

    lpsState_t        state;
    lpsState_t        stateNext;
    logic             newFrameSeen;
    logic             enterActive;
    logic             lockedNext;
    logic             winDone;
    logic             vStep;
    logic             vInWin;
    logic             hClr;
    logic             hStep;
    logic [CNT_W-1:0] vCount;
    logic [7:0]       unusedVIdx;
    logic [CNT_W-1:0] unusedHCount;

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    // vCount holds how many lines of this frame have started.
    assign winDone = (vCount >= V_END);

    always_comb begin
        stateNext   = state;
        enterActive = 1'b0;
        lockedNext  = locked;
        unique case (state)
            IDLE: begin
                if (newFrameIn) stateNext = ARMED;
            end
            ARMED: begin
                if (frameStart) begin
                    stateNext   = ACTIVE;
                    enterActive = 1'b1;
                    lockedNext  = 1'b1;
                end
            end
            ACTIVE: begin
                if (frameStart) begin
                    enterActive = 1'b1;
                    lockedNext  = winDone ? newFrameSeen : 1'b0;
                end else if (lineStart && (vCount == V_END)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (frameStart) begin
                    stateNext   = ACTIVE;
                    enterActive = 1'b1;
                    lockedNext  = newFrameSeen;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            newFrameSeen <= 1'b0;
            locked       <= 1'b0;
            underrunCnt  <= '0;
        end else begin
            state  <= stateNext;
            locked <= lockedNext;
            if (newFrameIn) begin
                newFrameSeen <= 1'b1;
            end else if (enterActive) begin
                newFrameSeen <= 1'b0;
            end
            if (nextLine && sameLine) begin
                underrunCnt <= satInc8(underrunCnt);
            end
        end
    end

    assign vStep = lineStart && ((state == ACTIVE) || enterActive);
    assign hClr  = lineStart || enterActive;
    assign hStep = pxlEn && vInWin && (state == ACTIVE) && !enterActive;

    scale_counter #(
        .OFFSET(V_OFFSET),
        .LEN   (SRC_H),
        .SCALE (SCALE),
        .CNT_W (CNT_W),
        .IDX_W (8)
    ) vAxis (
        .clk  (clk),
        .rst  (rst),
        .clr  (enterActive),
        .step (vStep),
        .inWin(vInWin),
        .wrap (nextLine),
        .idx  (unusedVIdx),
        .count(vCount)
    );

    scale_counter #(
        .OFFSET(H_OFFSET),
        .LEN   (SRC_W),
        .SCALE (SCALE),
        .CNT_W (CNT_W),
        .IDX_W (8)
    ) hAxis (
        .clk  (clk),
        .rst  (rst),
        .clr  (hClr),
        .step (hStep),
        .inWin(inWindow),
        .wrap (),
        .idx  (curPxl),
        .count(unusedHCount)
    );

endmodule

// File: tb/tb_line_pull_scheduler.sv
// Directed bench for line_pull_scheduler at default geometry (240x160 x4, 1280x720 raster).
module tb_line_pull_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       frameStart;
    logic       lineStart;
    logic       pxlEn;
    logic       newFrameIn;
    logic       sameLine;
    logic       nextLine;
    logic [7:0] curPxl;
    logic       inWindow;
    logic       locked;
    logic [7:0] underrunCnt;

    int nChecks = 0;
    int nErrors = 0;
    int lineNo  = 0;
    int pulseQ[$];

    always #5 clk = ~clk;

    line_pull_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .frameStart (frameStart),
        .lineStart  (lineStart),
        .pxlEn      (pxlEn),
        .newFrameIn (newFrameIn),
        .sameLine   (sameLine),
        .nextLine   (nextLine),
        .curPxl     (curPxl),
        .inWindow   (inWindow),
        .locked     (locked),
        .underrunCnt(underrunCnt)
    );

    always @(negedge clk) begin
        if (nextLine === 1'b1) pulseQ.push_back(lineNo);
    end

    task automatic checkEq(input string tag, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doLine(input int nPix, input bit vIn, input bit spot);
        int bad = 0;
        int expIn;
        int expPx;
        lineStart = 1'b1;
        tick();
        lineStart = 1'b0;
        for (int p = 0; p < nPix; p++) begin
            pxlEn = 1'b1;
            tick();
            expIn = (vIn && p >= 160 && p < 1120) ? 1 : 0;
            expPx = (expIn != 0) ? (p - 160) / 4 : 0;
            if (inWindow !== expIn[0] || curPxl !== expPx[7:0]) bad++;
            if (spot && (p == 0 || p == 159 || p == 160 || p == 163 || p == 164 ||
                         p == 1119 || p == 1120 || p == 1279)) begin
                checkEq($sformatf("inWindow@px%0d", p), int'(inWindow), expIn);
                checkEq($sformatf("curPxl@px%0d", p), int'(curPxl), expPx);
            end
        end
        pxlEn = 1'b0;
        if (nPix > 0) checkEq("hScanBadPixels", bad, 0);
        tick();
        tick();
    endtask

    task automatic runLines(input int first, input int last, input int pixLine,
                            input int nPix, input bit vIn, input bit spot);
        for (int l = first; l <= last; l++) begin
            lineNo = l;
            doLine((l == pixLine) ? nPix : 0, vIn, spot);
        end
    endtask

    task automatic startFrame();
        pulseQ.delete();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tick();
    endtask

    task automatic pulseNewFrame();
        newFrameIn = 1'b1;
        tick();
        newFrameIn = 1'b0;
        tick();
    endtask

    task automatic checkPulses(input string tag, input int expCnt,
                               input int expFirst, input int expLast);
        int bad = 0;
        checkEq({tag, "PullCount"}, pulseQ.size(), expCnt);
        if (expCnt > 0) begin
            checkEq({tag, "FirstPullLine"}, (pulseQ.size() > 0) ? pulseQ[0] : -1, expFirst);
            checkEq({tag, "LastPullLine"}, (pulseQ.size() > 0) ? pulseQ[$] : -1, expLast);
        end
        for (int i = 1; i < pulseQ.size(); i++) begin
            if (pulseQ[i] - pulseQ[i-1] != 4) bad++;
        end
        checkEq({tag, "PullSpacingBad"}, bad, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, "NextLine"}, int'(nextLine), 0);
        checkEq({tag, "CurPxl"}, int'(curPxl), 0);
        checkEq({tag, "InWindow"}, int'(inWindow), 0);
        checkEq({tag, "Locked"}, int'(locked), 0);
        checkEq({tag, "Underrun"}, int'(underrunCnt), 0);
    endtask

    initial begin
        rst        = 1'b0;
        frameStart = 1'b0;
        lineStart  = 1'b0;
        pxlEn      = 1'b0;
        newFrameIn = 1'b0;
        sameLine   = 1'b0;
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b1;
        tick();

        // Frame 1: locked frame, one full in-window pixel line.
        pulseNewFrame();
        startFrame();
        runLines(0, 719, 100, 1280, 1'b1, 1'b1);
        checkPulses("f1", 159, 44, 676);
        checkEq("f1Underrun", int'(underrunCnt), 0);
        checkEq("f1Locked", int'(locked), 1);

        // Frame 2: no new capture boundary, line buffer starved throughout.
        sameLine = 1'b1;
        startFrame();
        runLines(0, 719, -1, 0, 1'b0, 1'b0);
        checkPulses("f2", 159, 44, 676);
        checkEq("f2Locked", int'(locked), 0);
        checkEq("f2Underrun", int'(underrunCnt), 159);

        // Frame 3: underrun counter saturates.
        pulseNewFrame();
        startFrame();
        runLines(0, 719, -1, 0, 1'b0, 1'b0);
        checkPulses("f3", 159, 44, 676);
        checkEq("f3Locked", int'(locked), 1);
        checkEq("f3Underrun", int'(underrunCnt), 255);
        sameLine = 1'b0;

        // Frame 4: early frameStart at line 300, coinciding with a lineStart.
        pulseNewFrame();
        startFrame();
        checkEq("f4Locked", int'(locked), 1);
        runLines(0, 300, -1, 0, 1'b0, 1'b0);
        checkPulses("f4a", 65, 44, 300);
        pulseQ.delete();
        lineNo     = 0;
        frameStart = 1'b1;
        lineStart  = 1'b1;
        tick();
        frameStart = 1'b0;
        lineStart  = 1'b0;
        tick();
        tick();
        checkEq("abortLocked", int'(locked), 0);
        runLines(1, 199, -1, 0, 1'b0, 1'b0);
        lineNo = 200;
        doLine(600, 1'b1, 1'b0);
        checkPulses("f4b", 40, 44, 200);
        checkEq("preRstCurPxl", int'(curPxl), 109);
        checkEq("preRstInWindow", int'(inWindow), 1);
        checkEq("preRstUnderrun", int'(underrunCnt), 255);

        // Asynchronous reset mid-frame.
        rst = 1'b0;
        #1;
        checkAllZero("midRst");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // frameStart without a capture boundary must not start pulling.
        startFrame();
        runLines(0, 99, 50, 1280, 1'b0, 1'b0);
        checkPulses("noArm", 0, 0, 0);
        checkEq("noArmLocked", int'(locked), 0);

        // Capture boundary then frameStart from ARMED locks immediately.
        pulseNewFrame();
        startFrame();
        checkEq("armedLocked", int'(locked), 1);
        runLines(0, 49, -1, 0, 1'b0, 1'b0);
        checkPulses("armed", 2, 44, 48);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/line_pull_scheduler.md
# line_pull_scheduler

Sequences the line buffer's read side against the HDMI output raster. It issues one `nextLine` pull per source line and produces the source pixel index `curPxl`, integer-upscaled by `SCALE` and centred by the offsets. It sits between the output video timing generator and the line buffer / line cache. It also reports frame lock and line underruns for the OSD.

## Interface
Parameters:
- `SRC_W`, 240: source pixels per line.
- `SRC_H`, 160: source lines per frame.
- `SCALE`, 4: integer scale factor, 1..8, applied to both axes.
- `H_OFFSET`, 160: active output pixels left of the window.
- `V_OFFSET`, 40: active output lines above the window.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `frameStart`  in  1  one-cycle pulse, one cycle before the first active line of an output frame.
- `lineStart`  in  1  one-cycle pulse, one cycle before each active output line.
- `pxlEn`  in  1  high for each active output pixel.
- `newFrameIn`  in  1  pulse from the line buffer marking a captured frame boundary.
- `sameLine`  in  1  line buffer has no newer line available.
- `nextLine`  out  1  one-cycle pull request to the line buffer.
- `curPxl`  out  8  source pixel index, 0..SRC_W-1.
- `inWindow`  out  1  current output pixel lies inside the scaled image.
- `locked`  out  1  the last output frame was preceded by a captured frame boundary.
- `underrunCnt`  out  8  saturating count of pulls issued while `sameLine`=1.

## Operation
- States:
  - IDLE → ARMED on `newFrameIn`.
  - ARMED → ACTIVE on `frameStart`.
  - ACTIVE → DONE after the window's last output line completes: the `lineStart` following line V_OFFSET+SRC_H·SCALE−1, or the next `frameStart`.
  - DONE → ACTIVE on `frameStart`.
- `newFrameSeen` flag:
  - Set by `newFrameIn` in any state.
  - Cleared on entry to ACTIVE.
  - At each `frameStart` that enters ACTIVE, `locked` ← `newFrameSeen`. Exception: from ARMED, `locked` ← 1.
- Vertical:
  - `vLine` counts `lineStart` pulses from 0 within ACTIVE.
  - The window spans lines V_OFFSET..V_OFFSET+SRC_H·SCALE−1.
  - `vRep` counts 0..SCALE−1 across window lines.
  - At a window `lineStart` where `vRep` wraps from SCALE−1 to 0, `nextLine` pulses. No pull before the first window line; no pull after the last.
  - Exactly SRC_H−1 pulls occur per frame.
- Horizontal:
  - `hCnt` is cleared on `lineStart` and increments on `pxlEn`.
  - `inWindow`=1 when in the vertical window and H_OFFSET ≤ hCnt < H_OFFSET+SRC_W·SCALE.
  - `curPxl` advances every SCALE in-window `pxlEn`, starting at 0. It is held at 0 outside the window.
- Underruns: if `sameLine`=1 in the cycle `nextLine` is asserted, `underrunCnt` increments, saturating at 255.
- `frameStart` in ACTIVE (early frame): abort the current frame, restart ACTIVE, and set `locked` ← 0.
- `frameStart` and `lineStart` in the same cycle: `frameStart` is processed first, then that `lineStart` is counted as line 0.

## Timing
- All outputs are registered.
- `nextLine` asserts in the cycle after the qualifying `lineStart`, for exactly 1 cycle.
- `curPxl` and `inWindow` are valid in the cycle after the corresponding `pxlEn`.
- Reset values:
  - State = IDLE.
  - `nextLine`, `inWindow`, `locked` = 0.
  - `curPxl` = 0, `underrunCnt` = 0.
  - All counters = 0, `newFrameSeen` = 0.
- Reset asserted mid-frame returns to IDLE immediately. No pull is issued until `newFrameIn` followed by `frameStart`.
- In IDLE and ARMED, `nextLine` and `inWindow` stay 0.

## Structure
- Shared package entries:
  - `GBA_W`=240 and `GBA_H`=160, used as parameter defaults.
  - The state typedef `lpsState_t` {IDLE, ARMED, ACTIVE, DONE}.
- Sub-module `scale_counter`, instantiated twice (horizontal and vertical):
  - Parameters `OFFSET`, `LEN`, `SCALE`.
  - Inputs: clear and step.
  - Outputs: in-window, wrap-pulse, index.

## Test plan
- Reset release, `newFrameIn`, then `frameStart` with 720 lines × 1280 pixels:
  - `nextLine` pulses exactly 159 times, at output lines 44, 48, …, 676.
  - `underrunCnt`=0 and `locked`=1.
- In-window line, pixels 160..1119: `curPxl` steps 0,0,0,0,1,…,239; `inWindow`=1 only there. Pixels 0..159 and 1120..1279 give `curPxl`=0 and `inWindow`=0.
- Second `frameStart` without an intervening `newFrameIn` → `locked`=0; frame scheduling unchanged.
- `sameLine` held at 1 for a whole frame → `underrunCnt`=159. After two frames → 255, saturated.
- `frameStart` at output line 300 → no further pulls from the old frame, `locked`=0, `vLine` restarts at 0.
- `rst` low at output line 200 → all outputs 0 in the same cycle. With `frameStart` but no `newFrameIn` afterwards → no `nextLine`.
